seg_scan_pwm_ctrl: RTL and testbench
====================================

# seg_scan_pwm_ctrl

Parametrised time-multiplexed display scanner for N-digit seven-segment banks with per-frame PWM brightness, soft brightness ramping, per-digit blanking and leading-zero suppression. It sits between the counting/timekeeping logic (stop watch, clocks, counters) and the board's segment-select pins. It presents one digit's code per scan slot for an external segment decoder, and drives the matching select line gated by the PWM window. All digit data and brightness are latched at frame boundaries, so a displayed frame is always internally consistent.

## Interface
- CLK_FREQ, 200_000_000, clock frequency in Hz.
- SCAN_FREQ, 8_000, slot rate in Hz. Each digit is shown once per NUM_DIGITS slots. SLOT_CYCLES = CLK_FREQ/SCAN_FREQ and must be ≥ 2.
- NUM_DIGITS, 8, number of digits, 2..16.
- PWM_BITS, 4, brightness resolution in bits.
- SEL_ACTIVE_LOW, 0, 1 inverts seg_sel polarity (inactive = all ones).
- clk  in  1  system clock.
- arst  in  1  asynchronous, active-high reset.
- digit_val  in  4*NUM_DIGITS  digit i nibble at [4i+3:4i]. Digit 0 is least significant.
- special_mask  in  NUM_DIGITS  bit i set: digit i shows the special glyph (separator), and its value is ignored.
- dp_mask  in  NUM_DIGITS  decimal-point request per digit.
- blank_mask  in  NUM_DIGITS  bit i set: digit i is never selected.
- lz_blank  in  1  enables leading-zero suppression.
- duty_tgt  in  PWM_BITS  target brightness.
- ramp_en  in  1  1: brightness approaches duty_tgt by 1 LSB per frame. 0: brightness jumps to the target.
- dig_val  out  4  code of the current digit, for the decoder.
- dig_special  out  1  special glyph flag for the current digit.
- dig_dp  out  1  decimal point for the current digit.
- seg_sel  out  NUM_DIGITS  one-hot digit select, PWM-gated.
- frame_tick  out  1  one-cycle pulse at the start of each frame.
- duty_cur  out  PWM_BITS  currently applied brightness.

## Operation
- Slot counter cnt runs 0..SLOT_CYCLES-1 and then wraps.
- On the wrap, digit index idx advances: idx = (idx+1) mod NUM_DIGITS.
- When idx wraps NUM_DIGITS-1→0, frame_tick is asserted for exactly the first cycle of slot 0.
- Shadow registers for digit_val, special_mask, dp_mask, blank_mask, lz_blank and duty are loaded on the frame_tick cycle. Inputs may change at any time with no effect until the next frame.
- Brightness update on each frame_tick:
  - ramp_en=0: duty_cur ← duty_tgt.
  - ramp_en=1: duty_cur moves one step toward duty_tgt (+1 or -1), or holds if equal. It never overshoots.
- Leading-zero suppression is computed on shadow data with lz_blank=1. Scanning from digit NUM_DIGITS-1 downward, a digit is suppressed while its value is 0 and neither its special nor its dp bit is set. Suppression stops at the first digit that fails this test. Digit 0 is never suppressed.
- PWM threshold = (SLOT_CYCLES * duty_cur) >> PWM_BITS. The product is computed at full width with no truncation before the shift.
- The select bit idx is active when all of the following hold:
  - cnt < threshold;
  - the digit is not blanked;
  - the digit is not suppressed.
  - All other select bits are inactive.
- duty_cur=0 gives the display fully dark.
- Maximum brightness is (2^PWM_BITS-1)/2^PWM_BITS on-time.
- dig_val, dig_special and dig_dp always reflect shadow digit idx, independent of gating.

## Timing
- Reset values:
  - cnt=0, idx=0, frame_tick=0, duty_cur=0.
  - All shadow registers 0.
  - seg_sel inactive (all 0, or all 1 if SEL_ACTIVE_LOW).
  - dig_val=0, dig_special=0, dig_dp=0.
- First frame_tick occurs on the first cycle after reset release. cnt=0, idx=0 immediately follow reset, and that first cycle counts as a frame start.
- Outputs are combinational from registers only (idx, cnt, shadow regs, duty_cur). This guarantees no input-to-output path.
- Shadow data and duty_cur loaded at a frame_tick edge are visible from the cycle after frame_tick. Slot 0's first cycle therefore shows the previous frame's data.
- Frame period = NUM_DIGITS*SLOT_CYCLES cycles exactly, independent of blanking.
- A full ramp from 0 to 2^PWM_BITS-1 takes 2^PWM_BITS-1 frames.
- A duty_tgt change mid-ramp redirects the ramp at the next frame_tick.
- Asserting arst mid-frame forces all reset values asynchronously. The scan restarts at digit 0.

## Test plan
- Common bench parameters: CLK_FREQ=1000, SCAN_FREQ=100 (SLOT_CYCLES=10), NUM_DIGITS=4, PWM_BITS=4.
- Reset release, duty_tgt=15, ramp_en=0:
  - frame_tick pulses every 40 cycles;
  - idx sequence is 0,1,2,3;
  - from frame 2, each select is active 9 of every 10 cycles (threshold 9).
- duty_tgt=8, ramp_en=0: select active for cnt 0..4 (threshold 5) in every slot. duty_tgt=0 → seg_sel constantly inactive.
- ramp_en=1 from duty_cur=0, duty_tgt=5:
  - duty_cur reads 1,2,3,4,5 on successive frames, then holds;
  - retargeting to 3 at duty_cur=5 gives 4, then 3.
- Data applied mid-frame: digit_val=0x1234, lz_blank=0. dig_val does not change until after the next frame_tick, then reads 4,3,2,1 for idx 0..3.
- digit_val=0x0050 with lz_blank=1: digits 3 and 2 are never selected; digits 1 and 0 are selected. Setting dp_mask=4'b1000 additionally restores digits 3 and 2. blank_mask=4'b0001 suppresses digit 0 with no change to frame period.
- arst asserted at idx=2, cnt=6 with SEL_ACTIVE_LOW=1: seg_sel=4'b1111 immediately, and duty_cur=0. After release, frame_tick fires on the first cycle.

Source files
------------

// File: rtl/seg_scan_pwm_ctrl_if.sv
// seg_scan_pwm_ctrl_if
// Bundles the digit data, brightness controls and scan outputs of the
// seg_scan_pwm_ctrl display scanner.
//   master : the producer side (counting/timekeeping logic). It drives the
//            digit data and brightness controls and observes the scan outputs.
//   slave  : the scanner itself.
// Signals:
//   digit_val    4*NUM_DIGITS  digit i nibble at [4i+3:4i], digit 0 least significant
//   special_mask NUM_DIGITS    digit shows the special (separator) glyph
//   dp_mask      NUM_DIGITS    decimal-point request per digit
//   blank_mask   NUM_DIGITS    digit is never selected
//   lz_blank     1             enable leading-zero suppression
//   duty_tgt     PWM_BITS      target brightness
//   ramp_en      1             step brightness by 1 LSB per frame
//   dig_val      4             code of the digit in the current slot
//   dig_special  1             special glyph flag of the current digit
//   dig_dp       1             decimal point of the current digit
//   seg_sel      NUM_DIGITS    one-hot PWM-gated digit select
//   frame_tick   1             one-cycle pulse at the start of each frame
//   duty_cur     PWM_BITS      brightness currently applied
interface seg_scan_pwm_ctrl_if #(
   parameter int NUM_DIGITS = 8,
   parameter int PWM_BITS   = 4
);
   logic [4*NUM_DIGITS-1:0] digit_val;
   logic [NUM_DIGITS-1:0]   special_mask;
   logic [NUM_DIGITS-1:0]   dp_mask;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic                    lz_blank;
   logic [PWM_BITS-1:0]     duty_tgt;
   logic                    ramp_en;

   logic [3:0]              dig_val;
   logic                    dig_special;
   logic                    dig_dp;
   logic [NUM_DIGITS-1:0]   seg_sel;
   logic                    frame_tick;
   logic [PWM_BITS-1:0]     duty_cur;

   modport master (
      output digit_val, special_mask, dp_mask, blank_mask, lz_blank, duty_tgt, ramp_en,
      input  dig_val, dig_special, dig_dp, seg_sel, frame_tick, duty_cur
   );

   modport slave (
      input  digit_val, special_mask, dp_mask, blank_mask, lz_blank, duty_tgt, ramp_en,
      output dig_val, dig_special, dig_dp, seg_sel, frame_tick, duty_cur
   );
endinterface

// File: rtl/seg_scan_pwm_ctrl.sv
// seg_scan_pwm_ctrl
// Time-multiplexed scanner for an N-digit seven-segment bank. Each digit
// owns one slot of SLOT_CYCLES clocks per frame; the select line of the
// current digit is gated by a PWM window derived from the applied
// brightness. Digit data, masks and brightness are captured at the frame
// start so every displayed frame is internally consistent.
// Ports:
//   clk   system clock
//   arst  asynchronous active-high reset
//   bus   seg_scan_pwm_ctrl_if slave modport (data in, scan outputs out);
//         the interface instance must use the same NUM_DIGITS/PWM_BITS.
module seg_scan_pwm_ctrl #(
   parameter int CLK_FREQ       = 200_000_000,
   parameter int SCAN_FREQ      = 8_000,
   parameter int NUM_DIGITS     = 8,
   parameter int PWM_BITS       = 4,
   parameter bit SEL_ACTIVE_LOW = 1'b0
) (
   input logic                clk,
   input logic                arst,
   seg_scan_pwm_ctrl_if.slave bus
);

   localparam int SLOT_CYCLES = CLK_FREQ / SCAN_FREQ;
   localparam int CNT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int IDX_W       = $clog2(NUM_DIGITS);
   // Wide enough for SLOT_CYCLES * (2^PWM_BITS - 1) without truncation.
   localparam int PROD_W      = $clog2(SLOT_CYCLES + 1) + PWM_BITS;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [PROD_W-1:0] SLOT_WIDE = PROD_W'(SLOT_CYCLES);

   logic [CNT_W-1:0]          cnt;
   logic [IDX_W-1:0]          idx;
   logic [4*NUM_DIGITS-1:0]   sh_digit_val;
   logic [NUM_DIGITS-1:0]     sh_special;
   logic [NUM_DIGITS-1:0]     sh_dp;
   logic [NUM_DIGITS-1:0]     sh_blank;
   logic                      sh_lz;
   logic [PWM_BITS-1:0]       duty;

   logic                      frame_start;
   logic [NUM_DIGITS-1:0]     suppressed;
   logic [PROD_W-1:0]         threshold;
   logic                      sel_on;
   logic [NUM_DIGITS-1:0]     sel_raw;

   assign frame_start = (cnt == '0) && (idx == '0);

   // Slot/digit scan counters plus the frame-boundary capture of all
   // display data and the brightness update (jump or single-LSB ramp).
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         cnt          <= '0;
         idx          <= '0;
         sh_digit_val <= '0;
         sh_special   <= '0;
         sh_dp        <= '0;
         sh_blank     <= '0;
         sh_lz        <= 1'b0;
         duty         <= '0;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end

         if (frame_start) begin
            sh_digit_val <= bus.digit_val;
            sh_special   <= bus.special_mask;
            sh_dp        <= bus.dp_mask;
            sh_blank     <= bus.blank_mask;
            sh_lz        <= bus.lz_blank;
            if (!bus.ramp_en) begin
               duty <= bus.duty_tgt;
            end else if (bus.duty_tgt > duty) begin
               duty <= duty + 1'b1;
            end else if (bus.duty_tgt < duty) begin
               duty <= duty - 1'b1;
            end
         end
      end
   end

   // Leading-zero suppression: walk down from the most significant digit
   // and keep suppressing until a digit carries a value, a special glyph or
   // a decimal point. Digit 0 is outside the loop so it always stays lit.
   always_comb begin
      logic still_leading;
      suppressed    = '0;
      still_leading = sh_lz;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if ((sh_digit_val[4*i +: 4] != 4'd0) || sh_special[i] || sh_dp[i]) begin
            still_leading = 1'b0;
         end
         suppressed[i] = still_leading;
      end
   end

   // PWM on-window is the first (SLOT_CYCLES*duty)>>PWM_BITS cycles of the
   // slot, so full-scale duty never quite reaches 100% and duty 0 is dark.
   always_comb begin
      threshold = (SLOT_WIDE * PROD_W'(duty)) >> PWM_BITS;
      sel_on    = (PROD_W'(cnt) < threshold) && !sh_blank[idx] && !suppressed[idx];
      sel_raw   = '0;
      if (sel_on) begin
         sel_raw[idx] = 1'b1;
      end
   end

   assign bus.seg_sel     = SEL_ACTIVE_LOW ? ~sel_raw : sel_raw;
   assign bus.dig_val     = sh_digit_val[4*idx +: 4];
   assign bus.dig_special = sh_special[idx];
   assign bus.dig_dp      = sh_dp[idx];
   assign bus.duty_cur    = duty;
   // Masked by arst so the pulse stays low while reset is held, yet fires
   // in the very first cycle after release when cnt and idx are both zero.
   assign bus.frame_tick  = frame_start && !arst;

endmodule

// File: tb/tb_seg_scan_pwm_ctrl.sv
// tb_seg_scan_pwm_ctrl
// Scoreboard bench for seg_scan_pwm_ctrl. A cycle-count reference model
// derives the expected outputs of every cycle from elapsed time since reset
// and the inputs captured at each frame start; a separate monitor pops and
// compares them against the DUT half a cycle later.
module tb_seg_scan_pwm_ctrl;

   localparam int CLK_FREQ  = 1000;
   localparam int SCAN_FREQ = 100;
   localparam int ND        = 4;
   localparam int PB        = 4;
   localparam bit SAL       = 1'b1;
   localparam int SC        = CLK_FREQ / SCAN_FREQ;
   localparam int FRAME     = SC * ND;

   typedef struct packed {
      logic [3:0]    val;
      logic          sp;
      logic          dp;
      logic          ft;
      logic [ND-1:0] sel;
      logic [PB-1:0] duty;
   } exp_t;

   logic clk  = 1'b0;
   logic arst = 1'b1;

   always #5 clk = ~clk;

   seg_scan_pwm_ctrl_if #(.NUM_DIGITS(ND), .PWM_BITS(PB)) bus ();

   seg_scan_pwm_ctrl #(
      .CLK_FREQ      (CLK_FREQ),
      .SCAN_FREQ     (SCAN_FREQ),
      .NUM_DIGITS    (ND),
      .PWM_BITS      (PB),
      .SEL_ACTIVE_LOW(SAL)
   ) dut (
      .clk (clk),
      .arst(arst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   exp_t exp_q[$];

   // Reference model state: cycles since reset release and the data
   // captured at the most recent frame start.
   int         t = 0;
   logic [15:0] m_digits = '0;
   logic [3:0] m_special = '0;
   logic [3:0] m_dp = '0;
   logic [3:0] m_blank = '0;
   logic       m_lz = 1'b0;
   int         m_duty = 0;

   // Time advances one per clock; every FRAME cycles the live inputs are
   // captured and brightness moves toward (or jumps to) its target.
   always @(posedge clk or posedge arst) begin
      if (arst) begin
         t = 0; m_digits = '0; m_special = '0; m_dp = '0; m_blank = '0;
         m_lz = 1'b0; m_duty = 0;
      end else begin
         if (t % FRAME == 0) begin
            m_digits  = bus.digit_val;
            m_special = bus.special_mask;
            m_dp      = bus.dp_mask;
            m_blank   = bus.blank_mask;
            m_lz      = bus.lz_blank;
            if (!bus.ramp_en) m_duty = int'(bus.duty_tgt);
            else if (int'(bus.duty_tgt) > m_duty) m_duty = m_duty + 1;
            else if (int'(bus.duty_tgt) < m_duty) m_duty = m_duty - 1;
         end
         t = t + 1;
      end
   end

   // Highest digit that must stay lit under leading-zero suppression.
   function automatic int top_kept();
      int top = 0;
      for (int i = 0; i < ND; i++)
         if (m_digits[4*i +: 4] != 0 || m_special[i] || m_dp[i]) top = i;
      return top;
   endfunction

   // Expected outputs for the current cycle.
   always @(negedge clk) begin
      exp_t e;
      int   cnt, d, thr;
      logic [ND-1:0] sel;
      if (arst) begin
         e = '{val: 4'd0, sp: 1'b0, dp: 1'b0, ft: 1'b0, sel: SAL ? '1 : '0, duty: '0};
      end else begin
         cnt = t % SC;
         d   = (t / SC) % ND;
         thr = (SC * m_duty) / (1 << PB);
         sel = '0;
         if (cnt < thr && !m_blank[d] && (!m_lz || d <= top_kept())) sel[d] = 1'b1;
         e.val  = m_digits[4*d +: 4];
         e.sp   = m_special[d];
         e.dp   = m_dp[d];
         e.ft   = (t % FRAME == 0);
         e.sel  = SAL ? ~sel : sel;
         e.duty = PB'(m_duty);
      end
      exp_q.push_back(e);
   end

   task automatic check_output(input exp_t e);
      exp_t got;
      got = '{val: bus.dig_val, sp: bus.dig_special, dp: bus.dig_dp, ft: bus.frame_tick,
              sel: bus.seg_sel, duty: bus.duty_cur};
      vectors++;
      if (got !== e) begin
         miscompares++;
         $display("[TB] FAIL scan_out t=%0d: got val=%h sp=%b dp=%b ft=%b sel=%b duty=%0d, expected val=%h sp=%b dp=%b ft=%b sel=%b duty=%0d",
                  t, got.val, got.sp, got.dp, got.ft, got.sel, got.duty,
                  e.val, e.sp, e.dp, e.ft, e.sel, e.duty);
      end
   endtask

   // Monitor: compares each queued expectation while the outputs are stable.
   always @(negedge clk) begin
      #1;
      if (exp_q.size() > 0) check_output(exp_q.pop_front());
   end

   task automatic apply_stimulus(input logic [15:0] dv, input logic [3:0] sp, input logic [3:0] dpm,
                                 input logic [3:0] bl, input logic lz, input logic [3:0] tgt,
                                 input logic ramp);
      @(posedge clk);
      #1;
      bus.digit_val    = dv;
      bus.special_mask = sp;
      bus.dp_mask      = dpm;
      bus.blank_mask   = bl;
      bus.lz_blank     = lz;
      bus.duty_tgt     = tgt;
      bus.ramp_en      = ramp;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   initial begin
      logic [15:0] dv;
      bus.digit_val = 16'h9876; bus.special_mask = '0; bus.dp_mask = '0;
      bus.blank_mask = '0; bus.lz_blank = 1'b0; bus.duty_tgt = 4'd15; bus.ramp_en = 1'b0;

      wait_cycles(3);
      #1 arst = 1'b0;
      wait_cycles(3 * FRAME);

      // Half brightness, then fully dark.
      apply_stimulus(16'h9876, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'd8, 1'b0);
      wait_cycles(2 * FRAME);
      apply_stimulus(16'h9876, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0);
      wait_cycles(2 * FRAME);

      // Ramp up to 5 and then redirect down to 3.
      apply_stimulus(16'h9876, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'd5, 1'b1);
      wait_cycles(7 * FRAME);
      apply_stimulus(16'h9876, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'd3, 1'b1);
      wait_cycles(3 * FRAME);

      // Mid-frame data change.
      wait_cycles(13);
      apply_stimulus(16'h1234, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'd15, 1'b0);
      wait_cycles(2 * FRAME);

      // Leading-zero suppression, dp restoring, and blanking of digit 0.
      apply_stimulus(16'h0050, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'd15, 1'b0);
      wait_cycles(2 * FRAME);
      apply_stimulus(16'h0050, 4'b0000, 4'b1000, 4'b0000, 1'b1, 4'd15, 1'b0);
      wait_cycles(2 * FRAME);
      apply_stimulus(16'h0050, 4'b0000, 4'b0000, 4'b0001, 1'b1, 4'd15, 1'b0);
      wait_cycles(2 * FRAME);
      apply_stimulus(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'd15, 1'b0);
      wait_cycles(2 * FRAME);

      // Randomized traffic with many zero nibbles to stress suppression.
      for (int k = 0; k < 60; k++) begin
         for (int n = 0; n < ND; n++)
            dv[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
         apply_stimulus(dv, 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                        4'($urandom_range(0, 2) == 0 ? $urandom : 0),
                        4'($urandom_range(0, 2) == 0 ? $urandom : 0),
                        1'($urandom), 4'($urandom), 1'($urandom));
         wait_cycles($urandom_range(1, 30));
      end

      // Reset in the middle of digit 2's slot.
      apply_stimulus(16'h4321, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'd15, 1'b0);
      begin
         int k;
         for (k = 0; k < 4 * FRAME && (t % FRAME) != 26; k++) begin
            @(posedge clk);
            #1;
         end
         if ((t % FRAME) != 26) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL reset_align: got t%%FRAME=%0d, expected 26", t % FRAME);
         end
      end
      arst = 1'b1;
      wait_cycles(3);
      #1 arst = 1'b0;
      wait_cycles(2 * FRAME);

      wait_cycles(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
